// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, flush, an optional
// second (skid) entry and a saturating bubble counter. The payload is an opaque
// WIDTH-bit vector, so any set of stage signals can be packed into it.
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | valid_q=0, skid_valid_q=0: nothing held, ready_out=1
// BUSY  | valid_q=1, skid_valid_q=0: main entry presented, ready_out=1
// FULL  | valid_q=1, skid_valid_q=1: both entries held, ready_out=0
module pipe_stage_reg #(
   parameter int WIDTH      = 32,
   parameter int SKID       = 1,
   parameter int CLEAR_DATA = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             stall,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [WIDTH-1:0] data_in,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             valid_q, valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic adv, out_fire, in_fire;

   assign adv      = ready_in & ~stall;
   assign out_fire = valid_q & adv;
   assign in_fire  = valid_in & ready_out;

   // State register: entries, payloads and bubble counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q      <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
         cnt_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
         cnt_q        <= cnt_d;
      end
   end

   // Next-state: flush overrides the handshake; skid transitions follow the state table
   always_comb begin
      valid_d      = valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      cnt_d        = cnt_q;

      if (!valid_q && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (flush) begin
         valid_d      = 1'b0;
         skid_valid_d = 1'b0;
         if (CLEAR_DATA != 0) begin
            main_d = '0;
            skid_d = '0;
         end
      end else if (SKID == 0) begin
         if (in_fire) begin
            main_d  = data_in;
            valid_d = 1'b1;
         end else if (out_fire) begin
            valid_d = 1'b0;
         end
      end else begin
         case ({valid_q, skid_valid_q})
            2'b00: begin
               if (in_fire) begin
                  main_d  = data_in;
                  valid_d = 1'b1;
               end
            end
            2'b10: begin
               if (in_fire && out_fire) begin
                  main_d = data_in;
               end else if (in_fire) begin
                  skid_d       = data_in;
                  skid_valid_d = 1'b1;
               end else if (out_fire) begin
                  valid_d = 1'b0;
               end
            end
            2'b11: begin
               if (out_fire) begin
                  main_d       = skid_q;
                  skid_valid_d = 1'b0;
               end
            end
            default: begin
               // Unreachable (skid without main); recover to EMPTY.
               valid_d      = 1'b0;
               skid_valid_d = 1'b0;
            end
         endcase
      end
   end

   // Outputs: registered payload; ready is state-only when the skid entry exists
   always_comb begin
      if (SKID != 0) begin
         ready_out = ~skid_valid_q;
      end else begin
         ready_out = adv | ~valid_q;
      end
      valid_out  = valid_q;
      data_out   = main_q;
      occupancy  = {1'b0, valid_q} + {1'b0, skid_valid_q};
      bubble_cnt = cnt_q;
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset;

   // skid instance (SKID=1, CLEAR_DATA=1, CNT_W=4)
   logic        flush, stall, valid_in, ready_in;
   logic [31:0] data_in;
   logic        ready_out, valid_out;
   logic [31:0] data_out;
   logic [1:0]  occupancy;
   logic [3:0]  bubble_cnt;

   // single-entry instance (SKID=0, CLEAR_DATA=0, CNT_W=4)
   logic        flush0, stall0, valid_in0, ready_in0;
   logic [31:0] data_in0;
   logic        ready_out0, valid_out0;
   logic [31:0] data_out0;
   logic [1:0]  occupancy0;
   logic [3:0]  bubble_cnt0;

   int total = 0;
   int bad   = 0;

   // scoreboard model of the skid instance
   logic [31:0] q[$];
   int          bcnt;
   bit          zero_data;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(32), .SKID(1), .CLEAR_DATA(1), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .flush(flush), .stall(stall),
      .valid_in(valid_in), .ready_out(ready_out), .data_in(data_in),
      .valid_out(valid_out), .ready_in(ready_in), .data_out(data_out),
      .occupancy(occupancy), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_reg #(.WIDTH(32), .SKID(0), .CLEAR_DATA(0), .CNT_W(4)) dut0 (
      .clk(clk), .reset(reset), .flush(flush0), .stall(stall0),
      .valid_in(valid_in0), .ready_out(ready_out0), .data_in(data_in0),
      .valid_out(valid_out0), .ready_in(ready_in0), .data_out(data_out0),
      .occupancy(occupancy0), .bubble_cnt(bubble_cnt0)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle on the skid instance: drive, compare against the queue model
   // before the edge, then advance the model across the edge.
   task automatic cyc(input logic v, input logic [31:0] d, input logic r,
                      input logic s, input logic f);
      bit m_ready, m_out, m_in;
      valid_in = v; data_in = d; ready_in = r; stall = s; flush = f;
      @(negedge clk);
      m_ready = (q.size() < 2);
      chk("ready_out", ready_out, m_ready);
      chk("valid_out", valid_out, q.size() != 0);
      chk("occupancy", occupancy, q.size());
      chk("bubble_cnt", bubble_cnt, bcnt);
      if (q.size() != 0) chk("data_out", data_out, q[0]);
      else if (zero_data) chk("data_out_zero", data_out, 0);
      m_out = (q.size() != 0) && r && !s;
      m_in  = v && m_ready;
      if (q.size() == 0 && bcnt != 15) bcnt++;
      if (f) begin
         q.delete();
         zero_data = 1'b1;
      end else begin
         if (m_out) void'(q.pop_front());
         if (m_in) begin
            q.push_back(d);
            zero_data = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        r;
      logic        s;
      logic        f;
      logic        exp_ready;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic [1:0]  exp_occ;
   } vec_t;

   vec_t tbl[11];

   initial begin
      // SKID=0, CLEAR_DATA=0 expectations, starting from the reset state
      tbl[0]  = '{1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1, 2'd1};
      tbl[1]  = '{1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd2, 2'd1};
      tbl[2]  = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 2'd1};
      tbl[3]  = '{1'b1, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2, 2'd1};
      tbl[4]  = '{1'b0, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 2'd0};
      tbl[5]  = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 2'd0};
      tbl[6]  = '{1'b1, 32'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd6, 2'd1};
      tbl[7]  = '{1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd6, 2'd0};
      tbl[8]  = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6, 2'd0};
      tbl[9]  = '{1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd8, 2'd1};
      tbl[10] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd8, 2'd0};

      reset = 1'b0;
      flush = 0; stall = 0; valid_in = 0; ready_in = 0; data_in = '0;
      flush0 = 0; stall0 = 0; valid_in0 = 0; ready_in0 = 0; data_in0 = '0;
      q.delete(); bcnt = 0; zero_data = 1'b1;
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;

      // reset state, then streaming 1..4 with ready_in high
      cyc(0, 0, 1, 0, 0);
      cyc(1, 1, 1, 0, 0);
      cyc(1, 2, 1, 0, 0);
      cyc(1, 3, 1, 0, 0);
      cyc(1, 4, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);

      // backpressure: 0x11 then 0x22 with ready_in low, then drain
      cyc(1, 32'h11, 0, 0, 0);
      cyc(1, 32'h22, 0, 0, 0);
      cyc(1, 32'h33, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);

      // stall holds 0x55 for three cycles, then it transfers once
      cyc(1, 32'h55, 0, 0, 0);
      cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);

      // stall while upstream keeps sending: skid absorbs one beat
      cyc(1, 32'h61, 1, 1, 0);
      cyc(1, 32'h62, 1, 1, 0);
      cyc(1, 32'h63, 1, 1, 0);
      cyc(1, 32'h64, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);

      // flush in FULL with simultaneous input 0x77
      cyc(1, 32'h71, 0, 0, 0);
      cyc(1, 32'h72, 0, 0, 0);
      cyc(1, 32'h77, 0, 0, 1);
      cyc(0, 0, 1, 0, 0);
      chk("flush_data_zero", data_out, 32'h0);
      cyc(0, 0, 1, 0, 0);

      // counter saturation: idle then flush
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0);
      chk("bubble_sat", bubble_cnt, 4'hF);
      cyc(0, 0, 1, 0, 1);
      cyc(0, 0, 1, 0, 0);
      chk("bubble_after_flush", bubble_cnt, 4'hF);

      // random traffic against the scoreboard
      for (int i = 0; i < 300; i++) begin
         cyc($urandom_range(0, 1), $urandom, ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
      end

      // reset mid-stream from FULL, asserted between edges
      cyc(0, 0, 1, 0, 1);
      cyc(1, 32'hAAAA0001, 0, 0, 0);
      cyc(1, 32'hAAAA0002, 0, 0, 0);
      chk("pre_reset_occ", occupancy, 2);
      #2 reset = 1'b0;
      #1;
      chk("rst_valid_out", valid_out, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_bubble", bubble_cnt, 0);
      q.delete(); bcnt = 0; zero_data = 1'b1;
      valid_in = 0; ready_in = 0;
      @(posedge clk);
      #3 reset = 1'b1;
      cyc(0, 0, 1, 0, 0);
      cyc(1, 32'hBB, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);

      // single-entry instance, table-driven
      for (int i = 0; i < 11; i++) begin
         valid_in0 = tbl[i].v; data_in0 = tbl[i].d; ready_in0 = tbl[i].r;
         stall0 = tbl[i].s; flush0 = tbl[i].f;
         @(negedge clk);
         chk($sformatf("s0_ready[%0d]", i), ready_out0, tbl[i].exp_ready);
         @(posedge clk);
         #1;
         chk($sformatf("s0_valid[%0d]", i), valid_out0, tbl[i].exp_valid);
         chk($sformatf("s0_data[%0d]", i), data_out0, tbl[i].exp_data);
         chk($sformatf("s0_occ[%0d]", i), occupancy0, tbl[i].exp_occ);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
